// File: rtl/mac_buf_pkg.sv
// rtl/mac_buf_pkg.sv - shared FSM encoding, default sizes and row unpacking for the MAC operand buffer
package mac_buf_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Widest row the unpacker handles; instances narrow the result to their own shape.
  localparam int MAX_DATA_W = 32;
  localparam int MAX_DEPTH  = 64;
  localparam int MAX_ROW_W  = MAX_DATA_W * MAX_DEPTH;

  typedef logic [MAX_DEPTH-1:0][MAX_DATA_W-1:0] row_t;

  // Element 0 sits in the most significant slot of the packed row.
  function automatic row_t unpack_row(input logic [MAX_ROW_W-1:0] pin,
                                      input int depth, input int data_w);
    row_t                  r;
    logic [MAX_ROW_W-1:0]  sh;
    logic [MAX_DATA_W-1:0] mask;
    r    = '0;
    mask = ~({MAX_DATA_W{1'b1}} << data_w);
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (i < depth) begin
        sh   = pin >> ((depth - 1 - i) * data_w);
        r[i] = sh[MAX_DATA_W-1:0] & mask;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_buf_bank.sv
// rtl/mac_buf_bank.sv - one operand bank: parallel row write, stream read and guarded random read
module mac_buf_bank import mac_buf_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [DEPTH-1:0][DATA_W-1:0] row,
  input  logic [IDX_W-1:0]             s_idx,
  output logic [DATA_W-1:0]            s_data,
  input  logic [IDX_W-1:0]             r_idx,
  output logic [DATA_W-1:0]            r_data
);

  localparam logic [IDX_W:0] DEPTH_V = (IDX_W + 1)'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d = row;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The stream index is bounded by the counter; only the random port can run past the row.
  assign s_data = mem_q[s_idx];
  assign r_data = ({1'b0, r_idx} < DEPTH_V) ? mem_q[r_idx] : '0;

endmodule

// File: rtl/mac_pp_stream_buf.sv
// rtl/mac_pp_stream_buf.sv - ping-pong operand buffer streaming one row element per beat to the MAC
module mac_pp_stream_buf import mac_buf_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [DEPTH*DATA_W-1:0] pin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_W-1:0]       rd_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;

  logic                         ld_fire;
  logic                         beat;
  logic [DEPTH-1:0][DATA_W-1:0] row;
  logic [1:0][DATA_W-1:0]       s_data;
  logic [1:0][DATA_W-1:0]       r_data;

  function automatic logic [DEPTH-1:0][DATA_W-1:0] fit_row(input row_t r);
    for (int i = 0; i < DEPTH; i++) begin
      fit_row[i] = r[i][DATA_W-1:0];
    end
  endfunction

  assign row       = fit_row(unpack_row(MAX_ROW_W'(pin), DEPTH, DATA_W));
  assign ld_ready  = !rst && !full_q[wr_sel_q];
  assign ld_fire   = ld_valid && ld_ready;
  assign out_valid = !rst && (state_q == ST_STREAM);
  assign beat      = out_valid && out_ready;
  assign out_idx   = cnt_q;
  assign out_last  = out_valid && (cnt_q == LAST_IDX);
  assign out_data  = s_data[rd_sel_q];
  assign rd_data   = r_data[rd_sel_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      full_d   = 2'b00;
      wr_sel_d = 1'b0;
      rd_sel_d = 1'b0;
    end else begin
      if (ld_fire) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = !wr_sel_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (full_q[rd_sel_q]) begin
            state_d = ST_STREAM;
            cnt_d   = '0;
          end
        end
        default: begin
          if (beat) begin
            if (cnt_q == LAST_IDX) begin
              // Registered flag of the other bank decides whether the next row follows without a bubble.
              full_d[rd_sel_q] = 1'b0;
              rd_sel_d         = !rd_sel_q;
              cnt_d            = '0;
              state_d          = full_q[!rd_sel_q] ? ST_STREAM : ST_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    mac_buf_bank #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_bank (
      .clk   (clk),
      .we    (ld_fire && !flush && (wr_sel_q == 1'(b))),
      .row   (row),
      .s_idx (cnt_q),
      .s_data(s_data[b]),
      .r_idx (rd_idx),
      .r_data(r_data[b])
    );
  end

endmodule

// File: tb/tb_mac_pp_stream_buf.sv
// tb/tb_mac_pp_stream_buf.sv - scoreboard bench for the ping-pong operand stream buffer
module tb_mac_pp_stream_buf;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] idx;
    logic       last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst, flush, ld_valid, out_ready;
  logic         ld_ready, out_valid, out_last;
  logic [127:0] pin;
  logic [7:0]   out_data, rd_data;
  logic [3:0]   out_idx, rd_idx;

  logic         flush_b, ld_valid_b, out_ready_b;
  logic         ld_ready_b, out_valid_b, out_last_b;
  logic [95:0]  pin_b;
  logic [7:0]   out_data_b, rd_data_b;
  logic [3:0]   out_idx_b, rd_idx_b;

  beat_t exp_q[$];
  beat_t mon_b;
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  mac_pp_stream_buf #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .pin(pin), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  mac_pp_stream_buf #(.DATA_W(8), .DEPTH(12)) dut12 (
    .clk(clk), .rst(rst), .flush(flush_b), .ld_valid(ld_valid_b), .ld_ready(ld_ready_b),
    .pin(pin_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_idx(out_idx_b), .out_last(out_last_b), .rd_idx(rd_idx_b), .rd_data(rd_data_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] make_row(input logic [7:0] base);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[(15 - i) * 8 +: 8] = base + 8'(i);
    return r;
  endfunction

  task automatic push_row(input logic [7:0] base);
    beat_t b;
    for (int i = 0; i < 16; i++) begin
      b.d    = base + 8'(i);
      b.idx  = 4'(i);
      b.last = (i == 15);
      exp_q.push_back(b);
    end
  endtask

  task automatic do_load(input logic [7:0] base);
    logic ok;
    pin      = make_row(base);
    ld_valid = 1'b1;
    ok       = ld_ready;
    step();
    ld_valid = 1'b0;
    check("load_accepted", 32'(ok), 32'd1);
    if (ok) push_row(base);
  endtask

  task automatic wait_size(input int n, input string name);
    int c = 0;
    while (exp_q.size() > n && c < 200) begin
      step();
      c++;
    end
    check(name, 32'(exp_q.size()), 32'(n));
  endtask

  // Scoreboard monitor: one pop per accepted beat, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got data 0x%0h idx %0d, expected no beat", out_data, out_idx);
      end else begin
        mon_b = exp_q.pop_front();
        check("beat_data", 32'(out_data), 32'(mon_b.d));
        check("beat_idx", 32'(out_idx), 32'(mon_b.idx));
        check("beat_last", 32'(out_last), 32'(mon_b.last));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] hold_d;
    logic [3:0] hold_i;
    int         c;
    rst = 1'b1; flush = 1'b0; ld_valid = 1'b0; out_ready = 1'b0; pin = '0; rd_idx = '0;
    flush_b = 1'b0; ld_valid_b = 1'b0; out_ready_b = 1'b0; pin_b = '0; rd_idx_b = '0;

    // 1: reset values, single row stream
    step(); step();
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_ld_ready", 32'(ld_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    do_load(8'h00);
    check("valid_not_yet", 32'(out_valid), 32'd0);
    step();
    check("valid_rises", 32'(out_valid), 32'd1);
    wait_size(0, "t1_drained");
    check("t1_valid_drops", 32'(out_valid), 32'd0);

    // 2: fill both banks with the consumer stalled
    out_ready = 1'b0;
    do_load(8'h00);
    do_load(8'h10);
    check("t2_ld_ready_full", 32'(ld_ready), 32'd0);
    pin = make_row(8'h20);
    ld_valid = 1'b1;
    step(); step();
    ld_valid = 1'b0;
    check("t2_ld_ready_still", 32'(ld_ready), 32'd0);
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_hold_data", 32'(out_data), 32'h00);
    check("t2_hold_idx", 32'(out_idx), 32'd0);

    // 3: drain both banks back to back
    out_ready = 1'b1;
    c = 0;
    while (exp_q.size() > 0 && c < 64) begin
      step();
      c++;
      if (c == 15) check("t3_ld_ready_before_free", 32'(ld_ready), 32'd0);
      if (c == 16) check("t3_ld_ready_after_free", 32'(ld_ready), 32'd1);
    end
    check("t3_gapless_cycles", 32'(c), 32'd32);
    out_ready = 1'b0;
    step();

    // 4: alternating consumer stalls
    do_load(8'h40);
    step();
    for (int k = 0; k < 16; k++) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      hold_d = out_data;
      hold_i = out_idx;
      step();
      if (k < 15) begin
        check("t4_stall_valid", 32'(out_valid), 32'd1);
        check("t4_stall_data", 32'(out_data), 32'(hold_d));
        check("t4_stall_idx", 32'(out_idx), 32'(hold_i));
      end
    end
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check("t4_valid_drops", 32'(out_valid), 32'd0);

    // 5: random read and last beat on a 12-deep instance
    for (int i = 0; i < 12; i++) pin_b[(11 - i) * 8 +: 8] = 8'hA0 + 8'(i);
    ld_valid_b = 1'b1;
    step();
    ld_valid_b = 1'b0;
    step();
    for (int r = 0; r < 16; r++) begin
      rd_idx_b = 4'(r);
      #1;
      check("t5_rd_data", 32'(rd_data_b), (r < 12) ? 32'(8'hA0 + 8'(r)) : 32'd0);
    end
    out_ready_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("t5_idx12", 32'(out_idx_b), 32'(i));
      check("t5_last12", 32'(out_last_b), 32'(i == 11));
      step();
    end
    check("t5_valid12_drops", 32'(out_valid_b), 32'd0);
    out_ready_b = 1'b0;

    // 6a: flush mid-row with the other bank full
    out_ready = 1'b1;
    do_load(8'h50);
    do_load(8'h60);
    wait_size(27, "t6_five_beats");
    out_ready = 1'b0;
    flush = 1'b1;
    pin = make_row(8'hEE);
    ld_valid = 1'b1;
    step();
    flush = 1'b0;
    ld_valid = 1'b0;
    exp_q.delete();
    check("t6_flush_valid", 32'(out_valid), 32'd0);
    check("t6_flush_ld_ready", 32'(ld_ready), 32'd1);
    out_ready = 1'b1;
    do_load(8'h70);
    wait_size(0, "t6_flush_drained");
    check("t6_flush_idle", 32'(out_valid), 32'd0);

    // 6b: reset mid-row
    do_load(8'h80);
    wait_size(7, "t6_nine_beats");
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    check("t6_rst_ld_ready", 32'(ld_ready), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("t6_post_rst_valid", 32'(out_valid), 32'd0);
    check("t6_post_rst_ld_ready", 32'(ld_ready), 32'd1);
    out_ready = 1'b1;
    do_load(8'h90);
    wait_size(0, "t6_rst_drained");
    check("t6_rst_idle", 32'(out_valid), 32'd0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
